// File: rtl/dds_voice_bank.sv
// dds_voice_bank: time-multiplexed bank of DDS voices (saw/square/triangle) summed into one sample.
// Latency: a sample_tick in cycle T gives sample_valid in cycle T+NUM_VOICES+1; one voice is processed per cycle.
// Backpressure: cfg_ready is high only while idle, and config writes stall otherwise; ticks during a frame are dropped and flagged on overrun.
//
// Optional feature: define DDS_VOICE_BANK_HARD_SYNC_EN to enable hard sync.
// With hard sync, control bit3 on voice k>=1 resets that voice's phase to zero
// when voice k-1 wrapped earlier in the same frame.
//
// Ports:
//   clk, rst_n            - clock and asynchronous active-low reset
//   sample_tick           - strobe that starts a frame (dropped if a frame is running)
//   cfg_valid/cfg_ready   - config write handshake; cfg_ready is high only in IDLE
//   cfg_voice/reg/data    - write target: reg 0 tune, 1 control, 2 pulse width, 3 phase preset
//   sample_out            - unsigned mix of all voices, WAVE_W+3 bits
//   sample_valid          - one-cycle strobe marking a new sample_out
//   voice_wrap            - per-voice accumulator carry flags from the last frame
//   overrun               - one-cycle pulse after a dropped sample_tick
module dds_voice_bank #(
  parameter int NUM_VOICES = 4,
  parameter int ACC_W      = 16,
  parameter int TUNE_W     = 16,
  parameter int WAVE_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_voice,
  input  logic [1:0]            cfg_reg,
  input  logic [TUNE_W-1:0]     cfg_data,
  output logic [WAVE_W+2:0]     sample_out,
  output logic                  sample_valid,
  output logic [NUM_VOICES-1:0] voice_wrap,
  output logic                  overrun
);

  localparam int SUM_W = WAVE_W + 3;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
`ifdef DDS_VOICE_BANK_HARD_SYNC_EN
  localparam int CTRL_W = 4;
`else
  localparam int CTRL_W = 3;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;
  logic [IDX_W-1:0]      vidx;
  logic [ACC_W-1:0]      acc  [NUM_VOICES];
  logic [TUNE_W-1:0]     tune [NUM_VOICES];
  logic [CTRL_W-1:0]     ctrl [NUM_VOICES];
  logic [WAVE_W-1:0]     pw   [NUM_VOICES];
  logic [SUM_W-1:0]      mix_acc;
  logic [NUM_VOICES-1:0] wrap_acc;
`ifdef DDS_VOICE_BANK_HARD_SYNC_EN
  logic                  prev_wrap;  // wrap of the voice processed in the previous RUN cycle
`endif

  // Per-voice datapath for the voice currently selected by vidx
  logic [ACC_W-1:0]      cur_acc;
  logic [TUNE_W-1:0]     cur_tune;
  logic [CTRL_W-1:0]     cur_ctrl;
  logic [WAVE_W-1:0]     cur_pw;
  logic [ACC_W:0]        sum_ext;
  logic [ACC_W-1:0]      next_acc;
  logic                  cur_wrap;
  logic [WAVE_W-1:0]     p;
  logic [WAVE_W-1:0]     tri_v;
  logic [WAVE_W-1:0]     value;
  logic [SUM_W-1:0]      mix_next;
  logic [NUM_VOICES-1:0] wrap_next;
  logic                  last_voice;

  always_comb begin
    cur_acc  = '0;
    cur_tune = '0;
    cur_ctrl = '0;
    cur_pw   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (vidx == IDX_W'(i)) begin
        cur_acc  = acc[i];
        cur_tune = tune[i];
        cur_ctrl = ctrl[i];
        cur_pw   = pw[i];
      end
    end

    sum_ext = {1'b0, cur_acc} + {1'b0, ACC_W'(cur_tune)};

    if (!cur_ctrl[0]) begin
      next_acc = cur_acc;
      cur_wrap = 1'b0;
    end else begin
      next_acc = sum_ext[ACC_W-1:0];
      cur_wrap = sum_ext[ACC_W];
`ifdef DDS_VOICE_BANK_HARD_SYNC_EN
      // Hard sync: the follower restarts at phase 0 instead of advancing
      if (cur_ctrl[3] && (vidx != '0) && prev_wrap) begin
        next_acc = '0;
        cur_wrap = 1'b0;
      end
`endif
    end

    p     = next_acc[ACC_W-1 -: WAVE_W];
    tri_v = {p[WAVE_W-2:0], 1'b0};

    value = '0;
    if (cur_ctrl[0]) begin
      case (cur_ctrl[2:1])
        2'd0:    value = p;
        2'd1:    value = (p < cur_pw) ? '1 : '0;
        2'd2:    value = p[WAVE_W-1] ? ~tri_v : tri_v;
        default: value = '0;
      endcase
    end

    mix_next  = mix_acc + SUM_W'(value);
    wrap_next = wrap_acc;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (vidx == IDX_W'(i)) wrap_next[i] = cur_wrap;
    end

    last_voice = (vidx == IDX_W'(NUM_VOICES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vidx         <= '0;
      mix_acc      <= '0;
      wrap_acc     <= '0;
      sample_out   <= '0;
      voice_wrap   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      cfg_ready    <= 1'b1;
`ifdef DDS_VOICE_BANK_HARD_SYNC_EN
      prev_wrap    <= 1'b0;
`endif
      for (int i = 0; i < NUM_VOICES; i++) begin
        acc[i]  <= '0;
        tune[i] <= '0;
        ctrl[i] <= '0;
        pw[i]   <= {1'b1, {(WAVE_W-1){1'b0}}};
      end
    end else begin
      overrun <= sample_tick && (state != IDLE);

      // Config writes only land in IDLE, so they never collide with the RUN
      // update of acc. Out-of-range voice indices match no entry and vanish.
      if (cfg_valid && cfg_ready) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (cfg_voice == 3'(i)) begin
            case (cfg_reg)
              2'd0:    tune[i] <= cfg_data;
              2'd1:    ctrl[i] <= cfg_data[CTRL_W-1:0];
              2'd2:    pw[i]   <= cfg_data[WAVE_W-1:0];
              default: acc[i]  <= ACC_W'(cfg_data) << (ACC_W - TUNE_W);
            endcase
          end
        end
      end

      case (state)
        IDLE: begin
          sample_valid <= 1'b0;
          if (sample_tick) begin
            state     <= RUN;
            cfg_ready <= 1'b0;
            vidx      <= '0;
            mix_acc   <= '0;
            wrap_acc  <= '0;
`ifdef DDS_VOICE_BANK_HARD_SYNC_EN
            prev_wrap <= 1'b0;
`endif
          end
        end
        RUN: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (vidx == IDX_W'(i)) acc[i] <= next_acc;
          end
          mix_acc  <= mix_next;
          wrap_acc <= wrap_next;
`ifdef DDS_VOICE_BANK_HARD_SYNC_EN
          prev_wrap <= cur_wrap;
`endif
          if (last_voice) begin
            state        <= DONE;
            sample_out   <= mix_next;
            voice_wrap   <= wrap_next;
            sample_valid <= 1'b1;
          end else begin
            vidx <= vidx + 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          sample_valid <= 1'b0;
          cfg_ready    <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_voice_bank.sv
// tb_dds_voice_bank: directed scoreboard bench for dds_voice_bank (4 voices, 16-bit acc, 12-bit wave).
// Latency: expected frames are queued at tick time; a monitor compares each sample_valid.
// Backpressure: config writes are held until cfg_ready, including across a running frame.
module tb_dds_voice_bank;

  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_voice = '0;
  logic [1:0]  cfg_reg = '0;
  logic [15:0] cfg_data = '0;
  logic [14:0] sample_out;
  logic        sample_valid;
  logic [3:0]  voice_wrap;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;
  logic [18:0] exp_q[$];

  dds_voice_bank #(.NUM_VOICES(NV), .ACC_W(16), .TUNE_W(16), .WAVE_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_voice(cfg_voice),
    .cfg_reg(cfg_reg), .cfg_data(cfg_data), .sample_out(sample_out),
    .sample_valid(sample_valid), .voice_wrap(voice_wrap), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every sample_valid must match the oldest queued frame
  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_sample: got 0x%0h with nothing queued at %0t", sample_out, $time);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        chk("sample_out", int'(sample_out), int'(e[18:4]));
        chk("voice_wrap", int'(voice_wrap), int'(e[3:0]));
      end
    end
  end

  task automatic cfg_wr(input int v, input int r, input int d);
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_voice = 3'(v);
    cfg_reg   = 2'(r);
    cfg_data  = 16'(d);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // One frame: queue expectation, pulse tick, and check sample_valid timing.
  // Iteration k samples at the negedge inside cycle T+k.
  task automatic run_frame(input int exp_out, input int exp_wrap);
    int hits;
    int first;
    exp_q.push_back({15'(exp_out), 4'(exp_wrap)});
    hits = 0;
    first = -1;
    @(posedge clk); #1;
    sample_tick = 1'b1;
    for (int k = 0; k < NV + 4; k++) begin
      @(negedge clk);
      if (sample_valid) begin
        hits++;
        if (first < 0) first = k;
      end
      @(posedge clk); #1;
      if (k == 0) sample_tick = 1'b0;
    end
    chk("valid_latency", first, NV + 1);
    chk("valid_count", hits, 1);
  endtask

  initial begin
    int ovr_cnt;
    int val_cnt;
    int rdy_at;

    // Reset values while rst_n is held low
    repeat (3) @(negedge clk);
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_sample_valid", int'(sample_valid), 0);
    chk("rst_voice_wrap", int'(voice_wrap), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cfg_ready", int'(cfg_ready), 1);

    // All voices disabled: silent frame, T+5 latency
    run_frame(0, 0);

    // Saw on voice 0: 16 frames walk 0x100..0xF00 then wrap to 0
    cfg_wr(0, 0, 'h1000);
    cfg_wr(0, 1, 'h1);
    for (int k = 1; k <= 16; k++) run_frame((k * 'h100) & 'hFFF, (k == 16) ? 1 : 0);

    // Square, pw=0x800, quarter-cycle steps
    cfg_wr(0, 3, 0);
    cfg_wr(0, 0, 'h4000);
    cfg_wr(0, 1, 'h3);
    cfg_wr(0, 2, 'h800);
    run_frame('hFFF, 0);
    run_frame('h000, 0);
    run_frame('h000, 0);
    run_frame('hFFF, 1);

    // Triangle, same steps: p=0x400,0x800,0xC00,0x000
    cfg_wr(0, 1, 'h5);
    run_frame('h800, 0);
    run_frame('hFFF, 0);
    run_frame('h7FF, 0);
    run_frame('h000, 1);

    // Four square voices at p=0x100
    for (int v = 0; v < NV; v++) begin
      cfg_wr(v, 3, 0);
      cfg_wr(v, 0, 'h1000);
      cfg_wr(v, 2, 'h800);
      cfg_wr(v, 1, 'h3);
    end
    run_frame('h3FFC, 0);
    // Voice 3 to wave 3 (silent but enabled)
    cfg_wr(3, 1, 'h7);
    run_frame('h2FFD, 0);
    // Writes to voice indices beyond the bank must be discarded
    cfg_wr(4, 1, 0);
    cfg_wr(6, 1, 0);
    run_frame('h2FFD, 0);
    for (int v = 0; v < NV; v++) cfg_wr(v, 1, 0);

    // Overrun: second tick two cycles in; cfg write held through RUN
    cfg_wr(0, 3, 0);
    cfg_wr(0, 0, 'h1000);
    cfg_wr(0, 1, 'h1);
    exp_q.push_back({15'h100, 4'h0});
    ovr_cnt = 0;
    val_cnt = 0;
    rdy_at = -1;
    @(posedge clk); #1;
    sample_tick = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (overrun) ovr_cnt++;
      if (sample_valid) val_cnt++;
      if (cfg_valid && cfg_ready && rdy_at < 0) rdy_at = k;
      @(posedge clk); #1;
      if (k == 0) begin
        sample_tick = 1'b0;
        cfg_valid = 1'b1;
        cfg_voice = 3'd0;
        cfg_reg = 2'd0;
        cfg_data = 16'h2000;
      end
      if (k == 1) sample_tick = 1'b1;
      if (k == 2) sample_tick = 1'b0;
      if (k == rdy_at) cfg_valid = 1'b0;
    end
    chk("overrun_pulses", ovr_cnt, 1);
    chk("overrun_valids", val_cnt, 1);
    chk("held_cfg_accept_cycle", rdy_at, NV + 2);
    // New tune 0x2000 on top of acc 0x1000
    run_frame('h300, 0);
    cfg_wr(0, 1, 0);

    // Hard sync: v0 wraps in frame 2, v1 follows with sync bit
    cfg_wr(0, 3, 0);
    cfg_wr(1, 3, 0);
    cfg_wr(0, 0, 'h8000);
    cfg_wr(0, 1, 'h1);
    cfg_wr(1, 0, 'h1000);
    cfg_wr(1, 1, 'h9);
    run_frame('h900, 0);
`ifdef DDS_VOICE_BANK_HARD_SYNC_EN
    run_frame('h000, 1);
`else
    run_frame('h200, 1);
`endif

    // Reset mid-frame: frame abandoned, registers return to reset values
    @(posedge clk); #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_cfg_ready", int'(cfg_ready), 1);
    chk("midrst_sample_out", int'(sample_out), 0);
    chk("midrst_voice_wrap", int'(voice_wrap), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    val_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sample_valid) val_cnt++;
    end
    chk("midrst_no_valid", val_cnt, 0);
    // Reset pulse width is 0x800: square at p=0x100 is high without a pw write
    cfg_wr(0, 0, 'h1000);
    cfg_wr(0, 1, 'h3);
    run_frame('hFFF, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
